// File: rtl/posit_stream_accumulator.sv
// posit_stream_accumulator
// Folds a stream of N-bit posits into one sum per frame (a frame ends on in_last).
// Drives an external posit_adder through add_start/add_in1/add_in2 and waits
// for add_done before folding the result back. Only one add is in flight.
// Optional build macro: POSIT_ACC_TIMEOUT_EN enables an S_WAIT watchdog that
// aborts the frame with a NaR sum after TIMEOUT cycles without add_done.
module posit_stream_accumulator #(
    parameter int N       = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             aclk,
    input  logic             reset,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [N-1:0]     add_in1,
    output logic [N-1:0]     add_in2,
    output logic             add_start,
    input  logic [N-1:0]     add_result,
    input  logic             add_done,
    output logic [N-1:0]     out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_nar,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [N-1:0]     acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             last_reg, last_next;
    logic             nar_reg, nar_next;
    logic             add_start_reg, add_start_next;
    logic [N-1:0]     add_in1_reg, add_in1_next;
    logic [N-1:0]     add_in2_reg, add_in2_next;
    logic             accept;

`ifdef POSIT_ACC_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TMO_W-1:0] tmo_reg, tmo_next;
    logic             tmo_hit;

    // Watchdog fires on the TIMEOUT-th S_WAIT cycle without add_done
    assign tmo_hit = (tmo_reg == TMO_W'(TIMEOUT - 1));
`else
    // Keeps TIMEOUT referenced when the watchdog is compiled out
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // Operands are taken only while idle or between adds; never during reset
    assign in_ready = ~reset & ((state_reg == S_IDLE) | (state_reg == S_ACC));
    assign accept   = in_valid & in_ready;

    // Adder interface is fully registered so in1/in2 stay put until done
    assign add_start = add_start_reg;
    assign add_in1   = add_in1_reg;
    assign add_in2   = add_in2_reg;

    // Result stream is presented only in S_OUT and reads zero otherwise
    assign out_valid = (state_reg == S_OUT);
    assign out_data  = out_valid ? acc_reg : '0;
    assign out_count = out_valid ? cnt_reg : '0;
    assign out_nar   = out_valid & nar_reg;

    // Next-state and datapath decisions for the accumulate/wait/output loop
    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        last_next      = last_reg;
        nar_next       = nar_reg;
        add_start_next = 1'b0;
        add_in1_next   = add_in1_reg;
        add_in2_next   = add_in2_reg;
`ifdef POSIT_ACC_TIMEOUT_EN
        tmo_next       = tmo_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                // First element seeds the accumulator directly, no add needed
                if (accept) begin
                    acc_next   = in_data;
                    cnt_next   = CNT_W'(1);
                    nar_next   = (in_data == NAR);
                    last_next  = in_last;
                    state_next = in_last ? S_OUT : S_ACC;
                end
            end
            S_ACC: begin
                if (accept) begin
                    add_start_next = 1'b1;
                    add_in1_next   = acc_reg;
                    add_in2_next   = in_data;
                    last_next      = in_last;
                    cnt_next       = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);
                    state_next     = S_WAIT;
`ifdef POSIT_ACC_TIMEOUT_EN
                    tmo_next       = '0;
`endif
                end
            end
            S_WAIT: begin
                // add_done may already arrive in the same cycle as the start pulse
                if (add_done) begin
                    acc_next   = add_result;
                    nar_next   = nar_reg | (add_result == NAR);
                    state_next = last_reg ? S_OUT : S_ACC;
                end
`ifdef POSIT_ACC_TIMEOUT_EN
                else if (tmo_hit) begin
                    acc_next   = NAR;
                    nar_next   = 1'b1;
                    state_next = S_OUT;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
`endif
            end
            S_OUT: begin
                if (out_ready) begin
                    cnt_next   = '0;
                    nar_next   = 1'b0;
                    last_next  = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any pending add
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            last_reg      <= 1'b0;
            nar_reg       <= 1'b0;
            add_start_reg <= 1'b0;
            add_in1_reg   <= '0;
            add_in2_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            last_reg      <= last_next;
            nar_reg       <= nar_next;
            add_start_reg <= add_start_next;
            add_in1_reg   <= add_in1_next;
            add_in2_reg   <= add_in2_next;
        end
    end

`ifdef POSIT_ACC_TIMEOUT_EN
    // Watchdog counter register
    always_ff @(posedge aclk) begin
        if (reset) begin
            tmo_reg <= '0;
        end else begin
            tmo_reg <= tmo_next;
        end
    end
`endif

endmodule
